// File: rtl/nibbler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nibbler_pkg
//  Purpose  : Shared constants for the Nibbler control sequencer: opcodes,
//             ALU select codes, control-word bit positions, state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package nibbler_pkg;

    // Control word geometry
    localparam int CTL_W = 13;
    typedef logic [CTL_W-1:0] ctrl_word_t;

    // Opcodes (4-bit, taken straight from the fetch register)
    localparam logic [3:0] OP_JC   = 4'b0000;
    localparam logic [3:0] OP_JNC  = 4'b0001;
    localparam logic [3:0] OP_CMPI = 4'b0010;
    localparam logic [3:0] OP_CMPM = 4'b0011;
    localparam logic [3:0] OP_LIT  = 4'b0100;
    localparam logic [3:0] OP_IN   = 4'b0101;
    localparam logic [3:0] OP_LD   = 4'b0110;
    localparam logic [3:0] OP_ST   = 4'b0111;
    localparam logic [3:0] OP_JZ   = 4'b1000;
    localparam logic [3:0] OP_JNZ  = 4'b1001;
    localparam logic [3:0] OP_ADDI = 4'b1010;
    localparam logic [3:0] OP_ADDM = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_OUT  = 4'b1101;
    localparam logic [3:0] OP_NORI = 4'b1110;
    localparam logic [3:0] OP_NORM = 4'b1111;

    // ALU function select codes
    localparam logic [2:0] ALU_PASSA = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_PASSB = 3'b010;
    localparam logic [2:0] ALU_ADD   = 3'b011;
    localparam logic [2:0] ALU_NOR   = 3'b100;

    // Control-word bit positions
    localparam int CB_INCPC     = 12;
    localparam int CB_LOADPC    = 11;
    localparam int CB_LOADA     = 10;
    localparam int CB_LOADFLAGS = 9;
    localparam int CB_ALU_LSB   = 6;   // ALU_S occupies [8:6]
    localparam int CB_CSRAM     = 5;
    localparam int CB_WERAM     = 4;
    localparam int CB_OEALU     = 3;
    localparam int CB_OEIN      = 2;
    localparam int CB_OEOPRND   = 1;
    localparam int CB_LOADOUT   = 0;

    // Sequencer state encoding
    localparam logic [1:0] ST_FETCH = 2'b00;
    localparam logic [1:0] ST_EXEC  = 2'b01;
    localparam logic [1:0] ST_HALT  = 2'b10;

    // Control word with only the given single bit set
    function automatic ctrl_word_t ctl_bit(input int idx);
        ctrl_word_t w;
        w      = '0;
        w[idx] = 1'b1;
        return w;
    endfunction

    // Control word carrying only an ALU select code
    function automatic ctrl_word_t ctl_alu(input logic [2:0] sel);
        ctrl_word_t w;
        w                     = '0;
        w[CB_ALU_LSB +: 3]    = sel;
        return w;
    endfunction

endpackage : nibbler_pkg
`default_nettype wire

// File: rtl/nibbler_decode.sv
`default_nettype none
// ============================================================================
//  Module   : nibbler_decode
//  Purpose  : Combinational opcode/flag decoder producing the control word
//             used during EXECUTE. The sequencer gates it by state.
//  Revision : 1.0  initial release
// ============================================================================
module nibbler_decode
    import nibbler_pkg::*;
(
    input  logic [3:0]        instr_i,
    input  logic              c_flag_i,
    input  logic              z_flag_i,
    output logic [CTL_W-1:0]  ctrl_o
);

    // Shorthand groups shared by several opcodes
    ctrl_word_t w_inc;
    ctrl_word_t w_jmp;
    ctrl_word_t w_ldacc;   // loadA + loadFlags
    assign w_inc   = ctl_bit(CB_INCPC);
    assign w_jmp   = ctl_bit(CB_LOADPC);
    assign w_ldacc = ctl_bit(CB_LOADA) | ctl_bit(CB_LOADFLAGS);

    // Opcode decode; conditional jumps pick loadPC or incPC, never both
    always_comb begin
        ctrl_o = '0;
        case (instr_i)
            OP_JC:   ctrl_o = c_flag_i  ? w_jmp : w_inc;
            OP_JNC:  ctrl_o = !c_flag_i ? w_jmp : w_inc;
            OP_JZ:   ctrl_o = z_flag_i  ? w_jmp : w_inc;
            OP_JNZ:  ctrl_o = !z_flag_i ? w_jmp : w_inc;
            OP_JMP:  ctrl_o = w_jmp;
            OP_CMPI: ctrl_o = w_inc | ctl_bit(CB_OEOPRND) | ctl_alu(ALU_SUB)
                            | ctl_bit(CB_LOADFLAGS);
            OP_CMPM: ctrl_o = w_inc | ctl_bit(CB_CSRAM) | ctl_alu(ALU_SUB)
                            | ctl_bit(CB_LOADFLAGS);
            OP_LIT:  ctrl_o = w_inc | ctl_bit(CB_OEOPRND) | ctl_alu(ALU_PASSB) | w_ldacc;
            OP_IN:   ctrl_o = w_inc | ctl_bit(CB_OEIN)    | ctl_alu(ALU_PASSB) | w_ldacc;
            OP_LD:   ctrl_o = w_inc | ctl_bit(CB_CSRAM)   | ctl_alu(ALU_PASSB) | w_ldacc;
            OP_ST:   ctrl_o = w_inc | ctl_bit(CB_CSRAM) | ctl_bit(CB_WERAM)
                            | ctl_bit(CB_OEALU) | ctl_alu(ALU_PASSA);
            OP_ADDI: ctrl_o = w_inc | ctl_bit(CB_OEOPRND) | ctl_alu(ALU_ADD) | w_ldacc;
            OP_ADDM: ctrl_o = w_inc | ctl_bit(CB_CSRAM)   | ctl_alu(ALU_ADD) | w_ldacc;
            OP_NORI: ctrl_o = w_inc | ctl_bit(CB_OEOPRND) | ctl_alu(ALU_NOR) | w_ldacc;
            OP_NORM: ctrl_o = w_inc | ctl_bit(CB_CSRAM)   | ctl_alu(ALU_NOR) | w_ldacc;
            OP_OUT:  ctrl_o = w_inc | ctl_bit(CB_OEALU) | ctl_alu(ALU_PASSA)
                            | ctl_bit(CB_LOADOUT);
            default: ctrl_o = '0;
        endcase
    end

endmodule : nibbler_decode
`default_nettype wire

// File: rtl/nibbler_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : nibbler_sequencer
//  Purpose  : FETCH/EXECUTE control sequencer for the 4-bit Nibbler datapath
//             with run/halt/single-step control and a retired-instruction
//             counter.
//  Revision : 1.0  initial release
// ============================================================================
module nibbler_sequencer
    import nibbler_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter bit START_RUN = 1'b1
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              run_i,
    input  logic              step_i,
    input  logic [3:0]        instr_i,
    input  logic              c_flag_i,
    input  logic              z_flag_i,
    output logic              phase_o,
    output logic              fetch_en_o,
    output logic [CTL_W-1:0]  control_o,
    output logic              halted_o,
    output logic [CNT_W-1:0]  instr_cnt_o
);

    localparam logic [1:0] RESET_STATE = START_RUN ? ST_FETCH : ST_HALT;

    logic [1:0]       state_q,  state_d;
    logic             step_q;
    logic             single_q, single_d;   // current instruction was step-initiated
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             step_rise;
    ctrl_word_t       exec_word;

    nibbler_decode u_decode (
        .instr_i  (instr_i),
        .c_flag_i (c_flag_i),
        .z_flag_i (z_flag_i),
        .ctrl_o   (exec_word)
    );

    assign step_rise = step_i & ~step_q;

    // Next-state logic: step edges only matter while halted; run wins over step
    always_comb begin
        state_d  = state_q;
        single_d = single_q;
        case (state_q)
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC: begin
                state_d  = (run_i && !single_q) ? ST_FETCH : ST_HALT;
                single_d = 1'b0;
            end
            ST_HALT: begin
                if (run_i) begin
                    state_d  = ST_FETCH;
                    single_d = 1'b0;
                end else if (step_rise) begin
                    state_d  = ST_FETCH;
                    single_d = 1'b1;
                end
            end
            default: begin
                state_d  = RESET_STATE;
                single_d = 1'b0;
            end
        endcase
    end

    // Retire one instruction at the end of every EXEC cycle (wraps)
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_EXEC) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State, step-edge and counter registers
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= RESET_STATE;
            step_q   <= 1'b0;
            single_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_i;
            single_q <= single_d;
            cnt_q    <= cnt_d;
        end
    end

    // Moore outputs; enables are forced low while reset is held so the
    // datapath sees an all-quiet control word immediately
    always_comb begin
        fetch_en_o = (state_q == ST_FETCH) && !reset_i;
        phase_o    = (state_q == ST_EXEC)  && !reset_i;
        halted_o   = (state_q == ST_HALT);
        control_o  = '0;
        if (fetch_en_o) begin
            control_o = ctl_bit(CB_INCPC);
        end else if (phase_o) begin
            control_o = exec_word;
        end
    end

    assign instr_cnt_o = cnt_q;

endmodule : nibbler_sequencer
`default_nettype wire

// File: tb/tb_nibbler_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nibbler_sequencer
//  Purpose  : Self-checking bench for nibbler_sequencer. One free-running
//             instance (defaults) and one halted-at-reset instance with a
//             4-bit counter for single-step and wrap behaviour.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nibbler_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running instance
    logic        rst_s, run_s, step_s, c_s, z_s;
    logic [3:0]  instr_s;
    logic        phase_s, fetch_s, halted_s;
    logic [12:0] ctl_s;
    logic [15:0] cnt_s;

    // Halt-at-reset instance, 4-bit counter
    logic        rst_h, run_h, step_h, c_h, z_h;
    logic [3:0]  instr_h;
    logic        phase_h, fetch_h, halted_h;
    logic [12:0] ctl_h;
    logic [3:0]  cnt_h;

    nibbler_sequencer #(.CNT_W(16), .START_RUN(1'b1)) u_s (
        .clock_i(clk), .reset_i(rst_s), .run_i(run_s), .step_i(step_s),
        .instr_i(instr_s), .c_flag_i(c_s), .z_flag_i(z_s),
        .phase_o(phase_s), .fetch_en_o(fetch_s), .control_o(ctl_s),
        .halted_o(halted_s), .instr_cnt_o(cnt_s)
    );

    nibbler_sequencer #(.CNT_W(4), .START_RUN(1'b0)) u_h (
        .clock_i(clk), .reset_i(rst_h), .run_i(run_h), .step_i(step_h),
        .instr_i(instr_h), .c_flag_i(c_h), .z_flag_i(z_h),
        .phase_o(phase_h), .fetch_en_o(fetch_h), .control_o(ctl_h),
        .halted_o(halted_h), .instr_cnt_o(cnt_h)
    );

    int n_vec = 0;
    int n_bad = 0;
    int exp_s = 0;   // expected retired count, free-running instance
    int exp_h = 0;   // expected retired count, halt instance (mod 16)

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Golden EXEC control word, written from the opcode table
    function automatic logic [12:0] golden(input logic [3:0] op, input logic c, input logic z);
        case (op)
            4'h0: return c  ? 13'h0800 : 13'h1000;   // JC
            4'h1: return !c ? 13'h0800 : 13'h1000;   // JNC
            4'h8: return z  ? 13'h0800 : 13'h1000;   // JZ
            4'h9: return !z ? 13'h0800 : 13'h1000;   // JNZ
            4'hC: return 13'h0800;                   // JMP
            4'h2: return 13'h1242;                   // CMPI
            4'h3: return 13'h1260;                   // CMPM
            4'h4: return 13'h1682;                   // LIT
            4'h5: return 13'h1684;                   // IN
            4'h6: return 13'h16A0;                   // LD
            4'h7: return 13'h1038;                   // ST
            4'hA: return 13'h16C2;                   // ADDI
            4'hB: return 13'h16E0;                   // ADDM
            4'hD: return 13'h1009;                   // OUT
            4'hE: return 13'h1702;                   // NORI
            4'hF: return 13'h1720;                   // NORM
            default: return 13'h0000;
        endcase
    endfunction

    // Invariants on both instances, every cycle
    always @(negedge clk) begin
        if (!rst_s) begin
            check_val("inv_pc_s",  32'(ctl_s[12] & ctl_s[11]), 0);
            check_val("inv_we_s",  32'(ctl_s[4] & ~ctl_s[5]), 0);
            check_val("inv_oe_s",  32'($countones(ctl_s[3:1]) > 1), 0);
            if (!phase_s && !fetch_s) check_val("idle_ctl_s", 32'(ctl_s), 0);
        end
        if (!rst_h) begin
            check_val("inv_pc_h",  32'(ctl_h[12] & ctl_h[11]), 0);
            check_val("inv_we_h",  32'(ctl_h[4] & ~ctl_h[5]), 0);
            check_val("inv_oe_h",  32'($countones(ctl_h[3:1]) > 1), 0);
            if (!phase_h && !fetch_h) check_val("idle_ctl_h", 32'(ctl_h), 0);
        end
    end

    // One instruction on the free-running instance; entered mid-FETCH,
    // returns mid-FETCH of the next instruction
    task automatic s_instr(input logic [3:0] op, input logic c, input logic z);
        check_val("s_fetch_en", 32'(fetch_s), 1);
        check_val("s_fetch_ph", 32'(phase_s), 0);
        check_val("s_fetch_ctl", 32'(ctl_s), 32'h1000);
        check_val("s_fetch_cnt", 32'(cnt_s), 32'(exp_s));
        instr_s = op; c_s = c; z_s = z;
        step_s  = 1'($urandom_range(0, 1));   // ignored while running
        @(negedge clk); #1;
        check_val("s_exec_ph", 32'(phase_s), 1);
        check_val("s_exec_fe", 32'(fetch_s), 0);
        check_val($sformatf("s_exec_ctl op%0h c%0d z%0d", op, c, z), 32'(ctl_s), 32'(golden(op, c, z)));
        exp_s = (exp_s + 1) % 65536;
        @(negedge clk); #1;
    endtask

    // One step pulse on the halt instance; step held for 'hold' cycles
    task automatic h_step(input int hold);
        instr_h = 4'($urandom_range(0, 15));
        c_h     = 1'($urandom_range(0, 1));
        z_h     = 1'($urandom_range(0, 1));
        step_h  = 1'b1;
        for (int i = 1; i <= hold + 4; i++) begin
            @(negedge clk); #1;
            if (i == 1) begin
                check_val("h_step_fetch", 32'(fetch_h), 1);
                check_val("h_step_run",   32'(halted_h), 0);
            end else if (i == 2) begin
                check_val("h_step_ph",  32'(phase_h), 1);
                check_val("h_step_ctl", 32'(ctl_h), 32'(golden(instr_h, c_h, z_h)));
                exp_h = (exp_h + 1) % 16;
            end else begin
                check_val("h_step_halt", 32'(halted_h), 1);
                check_val("h_step_fe",   32'(fetch_h), 0);
                check_val("h_step_cnt",  32'(cnt_h), 32'(exp_h));
            end
            if (i == hold) step_h = 1'b0;
        end
    endtask

    initial begin
        logic [3:0] op;
        int         base;
        int         idx;

        rst_s = 1'b1; run_s = 1'b1; step_s = 1'b0; instr_s = '0; c_s = 1'b0; z_s = 1'b0;
        rst_h = 1'b1; run_h = 1'b0; step_h = 1'b0; instr_h = '0; c_h = 1'b0; z_h = 1'b0;

        // Reset state
        #1;
        check_val("rst_phase", 32'(phase_s), 0);
        check_val("rst_fetch", 32'(fetch_s), 0);
        check_val("rst_ctl",   32'(ctl_s), 0);
        check_val("rst_cnt",   32'(cnt_s), 0);
        check_val("rst_halt",  32'(halted_s), 0);
        check_val("rst_halt_h", 32'(halted_h), 1);
        check_val("rst_fetch_h", 32'(fetch_h), 0);

        @(negedge clk); #1;
        rst_s = 1'b0; rst_h = 1'b0;
        #1;
        check_val("post_rst_fetch", 32'(fetch_s), 1);
        check_val("post_rst_phase", 32'(phase_s), 0);

        // All 16 opcodes x 4 flag combos, randomly permuted
        base = $urandom_range(0, 63);
        for (int i = 0; i < 64; i++) begin
            idx = (i * 37 + base) % 64;
            op  = 4'(idx / 4);
            s_instr(op, 1'(idx % 2), 1'((idx / 2) % 2));
        end

        // Random instruction stream
        for (int i = 0; i < 40; i++) begin
            s_instr(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of EXEC
        instr_s = 4'b0100; step_s = 1'b0;
        @(negedge clk); #1;
        check_val("pre_rst_exec", 32'(phase_s), 1);
        rst_s = 1'b1;
        #1;
        check_val("mid_rst_phase", 32'(phase_s), 0);
        check_val("mid_rst_fetch", 32'(fetch_s), 0);
        check_val("mid_rst_ctl",   32'(ctl_s), 0);
        check_val("mid_rst_cnt",   32'(cnt_s), 0);
        @(negedge clk); #1;
        rst_s = 1'b0;
        exp_s = 0;
        #1;
        check_val("rel_rst_fetch", 32'(fetch_s), 1);
        check_val("rel_rst_phase", 32'(phase_s), 0);

        // LIT: count goes 0 -> 1
        s_instr(4'b0100, 1'b0, 1'b0);
        check_val("lit_cnt", 32'(cnt_s), 1);

        // Drop run during EXEC -> halt
        instr_s = 4'b0101;
        @(negedge clk); #1;
        run_s = 1'b0;
        exp_s = exp_s + 1;
        @(negedge clk); #1;
        check_val("s_halted", 32'(halted_s), 1);
        check_val("s_halt_ctl", 32'(ctl_s), 0);
        check_val("s_halt_cnt", 32'(cnt_s), 32'(exp_s));

        // Halt instance has idled since reset: check 10 quiet cycles
        for (int i = 0; i < 10; i++) begin
            instr_h = 4'($urandom_range(0, 15));
            @(negedge clk); #1;
            check_val("h_idle_halt", 32'(halted_h), 1);
            check_val("h_idle_ctl",  32'(ctl_h), 0);
            check_val("h_idle_fe",   32'(fetch_h), 0);
        end

        // Three step pulses, one held 5 cycles
        h_step(1);
        h_step(5);
        h_step(2);
        check_val("h_three_steps", 32'(cnt_h), 3);

        // run and step rise together: run governs thereafter
        instr_h = 4'b1101;
        run_h = 1'b1; step_h = 1'b1;
        @(negedge clk); #1;
        check_val("both_fetch", 32'(fetch_h), 1);
        @(negedge clk); #1;
        check_val("both_exec", 32'(phase_h), 1);
        exp_h = (exp_h + 1) % 16;
        step_h = 1'b0;
        @(negedge clk); #1;
        check_val("both_refetch", 32'(fetch_h), 1);
        run_h = 1'b0;
        @(negedge clk); #1;
        check_val("both_exec2", 32'(phase_h), 1);
        exp_h = (exp_h + 1) % 16;
        @(negedge clk); #1;
        check_val("both_halt", 32'(halted_h), 1);
        check_val("both_cnt",  32'(cnt_h), 32'(exp_h));

        // Counter wrap: 17 instructions on a 4-bit counter
        rst_h = 1'b1;
        #1;
        check_val("h_rst_cnt", 32'(cnt_h), 0);
        run_h = 1'b1;
        @(negedge clk); #1;
        rst_h = 1'b0;
        #1;
        check_val("h_rst_halt", 32'(halted_h), 1);
        for (int k = 0; k < 17; k++) begin
            instr_h = 4'($urandom_range(0, 15));
            @(negedge clk); #1;
            check_val("wrap_fetch", 32'(fetch_h), 1);
            @(negedge clk); #1;
            check_val("wrap_exec_cnt", 32'(cnt_h), 32'(k % 16));
            if (k == 16) run_h = 1'b0;
        end
        @(negedge clk); #1;
        check_val("wrap_cnt", 32'(cnt_h), 1);
        check_val("wrap_halt", 32'(halted_h), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_nibbler_sequencer
`default_nettype wire
